gmii_fcs_insert: RTL
====================

Name: gmii_fcs_insert

Overview:
- Sits directly downstream of the MAC frame sender, on the GMII transmit path toward the PHY/SGMII adapter.
- Input is a GMII byte stream carrying preamble, SFD, header and payload, but no valid FCS.
- It computes the real Ethernet CRC32 over the post-SFD bytes and zero-pads short frames to the 60-byte minimum.
- It appends the 4-byte FCS, then enforces the inter-frame gap before accepting the next frame.

Parameters:
MIN_DATA, 60, minimum post-SFD byte count before FCS; 0 disables padding
IFG_CYCLES, 12, idle cycles (tx_en=0) forced after last FCS byte
MAX_PREAMBLE, 8, bytes allowed before SFD (0xD5) must appear

Ports:
gmii_clk  input  1  GMII 125 MHz transmit clock
rst  input  1  reset
in_tx_en  input  1  upstream frame valid
in_tx_data  input  8  upstream byte
gmii_tx_en  output  1  to PHY
gmii_tx_err  output  1  to PHY, error/abort marker
gmii_tx_data  output  8  to PHY
busy  output  1  high whenever state != IDLE
overrun  output  1  one-cycle pulse: in_tx_en high while in PAD/FCS/IFG

Behaviour:
- Interface: single clock gmii_clk; rst is synchronous, active-high.
- While rst is high, all outputs are 0, state is IDLE, CRC register is 0xFFFFFFFF and all counters are 0.
- All outputs are registered. A pass-through byte appears at the outputs 1 cycle after it is sampled.
- States: IDLE, PREAMBLE, DATA, PAD, FCS, IFG, DRAIN.
- IDLE: a new frame starts only on a rising edge of in_tx_en (in_tx_en=1, registered previous value=0).
  - On a start, output the byte.
  - If the byte is 0xD5, go to DATA; otherwise go to PREAMBLE with pre_cnt=1.
  - in_tx_en held high across the return to IDLE does not start a frame.
- PREAMBLE: pass bytes through; pre_cnt counts them.
  - Byte 0xD5 → DATA. The CRC is not updated for preamble or SFD bytes.
  - If pre_cnt reaches MAX_PREAMBLE without an SFD → DRAIN.
  - If in_tx_en falls here → DRAIN.
- DATA, in_tx_en=1: output the byte, crc ← crc32_d8(crc, byte), data_cnt++ (11 bits, saturating at 2047).
- DATA, in_tx_en=0:
  - If data_cnt < MIN_DATA: output 0x00, update the CRC with 0x00, data_cnt++, go to PAD.
  - Otherwise: output FCS byte 0, go to FCS with fcs_idx=1.
- PAD: output 0x00 with CRC update until data_cnt = MIN_DATA, then behave exactly like the DATA/in_tx_en=0 exit to FCS. No idle cycle is inserted between pad and FCS.
- FCS: fcs = ~crc. Bytes go out as fcs[7:0], [15:8], [23:16], [31:24].
  - The CRC register is frozen during this state.
  - After the 4th byte → IFG with ifg_cnt=0.
- IFG: gmii_tx_en=0, gmii_tx_data=0. After IFG_CYCLES cycles → IDLE; reload crc=0xFFFFFFFF and clear the counters.
- DRAIN (abort): gmii_tx_en=1 and gmii_tx_err=1 with data 0x00 while in_tx_en stays high. No FCS is sent. When in_tx_en falls → IFG.
- gmii_tx_en stays continuous from the first output byte through the last FCS byte.
- gmii_tx_err is 1 only in DRAIN.
- busy: high from the cycle after a start until IDLE is re-entered.
- overrun: pulses every cycle in_tx_en=1 in PAD/FCS/IFG. Input bytes in those states are discarded.
- CRC: Ethernet CRC32, poly 0x04C11DB7 reflected (0xEDB88320), LSB-first per byte, init 0xFFFFFFFF, final complement.
- Reset asserted mid-frame: outputs go to 0 on the next edge, with no FCS and no IFG.

Decomposition:
- eth_pkg: ETH_PREAMBLE=0x55, ETH_SFD=0xD5, CRC32_INIT=0xFFFFFFFF, CRC32_POLY_REFL=0xEDB88320, CRC32_RESIDUE=0xDEBB20E3, and a state enum typedef.
- crc32_d8: one combinational sub-module, next-CRC for one byte (32-bit crc_in, 8-bit data → 32-bit crc_out). It is reused later by the receive-side FCS checker.

Test Plan:
- MIN_DATA=0: send 7×0x55, 0xD5, then ASCII "123456789". Output must be those 17 bytes followed by FCS 0x26, 0x39, 0xF4, 0xCB; then 12 idle cycles; busy falls on the following cycle.
- Default params: send preamble+SFD, 14-byte header and 28-byte payload (42 bytes post-SFD). Output must be 18 bytes of 0x00 pad, then 4 FCS bytes. Running the raw CRC (no final complement) over the 64 post-SFD output bytes must give 0xDEBB20E3.
- Send a 1514-byte post-SFD frame. There is no pad, the FCS matches the software model, and gmii_tx_en is continuous for 8+1514+4 cycles.
- Assert in_tx_en during the FCS and IFG of the previous frame. overrun must pulse on each such cycle, those bytes must not be transmitted, and no new frame may start until in_tx_en falls and rises again.
- Send 9×0x55 with no SFD. The 9th output cycle and later carry gmii_tx_err=1, no FCS is sent, and IFG follows the fall of in_tx_en.
- Pulse rst during the DATA state. On the next cycle gmii_tx_en=0, gmii_tx_err=0, busy=0, and the next frame's FCS is correct (the CRC was re-initialised).

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, the transmit FCS state encoding and the
// byte-wide reflected CRC32 step used by both transmit and receive FCS logic.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_PAD      = 3'd3,
        ST_FCS      = 3'd4,
        ST_IFG      = 3'd5,
        ST_DRAIN    = 3'd6
    } fcs_state_t;

    // Bits enter LSB first, so the reflected polynomial shifts right.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-CRC for one byte of Ethernet CRC32 (reflected, LSB first).
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    assign crc_out = crc32_byte(crc_in, data);

endmodule

// File: rtl/gmii_fcs_insert.sv
// GMII transmit FCS inserter: passes preamble/SFD/data, pads short frames,
// appends the CRC32 FCS and then holds the line idle for the inter-frame gap.
module gmii_fcs_insert
    import eth_pkg::*;
#(
    parameter int MIN_DATA     = 60,
    parameter int IFG_CYCLES   = 12,
    parameter int MAX_PREAMBLE = 8
) (
    input  logic       gmii_clk,
    input  logic       rst,
    input  logic       in_tx_en,
    input  logic [7:0] in_tx_data,
    output logic       gmii_tx_en,
    output logic       gmii_tx_err,
    output logic [7:0] gmii_tx_data,
    output logic       busy,
    output logic       overrun
);

    localparam logic [10:0] MIN_C    = 11'(MIN_DATA);
    localparam logic [3:0]  MAX_PRE  = 4'(MAX_PREAMBLE);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);

    fcs_state_t  state_r, state_s;
    logic [31:0] crc_r, crc_s, crc_next_s, fcs_s;
    logic [7:0]  crc_byte_s;
    logic [10:0] data_cnt_r, data_cnt_s, data_cnt_inc_s;
    logic [3:0]  pre_cnt_r, pre_cnt_s;
    logic [1:0]  fcs_idx_r, fcs_idx_s;
    logic [7:0]  ifg_cnt_r, ifg_cnt_s;
    logic        en_prev_r;
    logic        tx_en_s, tx_err_s, ovr_s;
    logic [7:0]  tx_data_s;

    // Only live data bytes feed the CRC; pad bytes contribute zeros.
    assign crc_byte_s     = (state_r == ST_DATA && in_tx_en) ? in_tx_data : 8'h00;
    assign fcs_s          = ~crc_r;
    assign data_cnt_inc_s = (data_cnt_r == 11'h7FF) ? data_cnt_r : data_cnt_r + 11'd1;

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc_r),
        .data    (crc_byte_s),
        .crc_out (crc_next_s)
    );

    // Next-state, counter and output-byte selection.
    always_comb begin
        state_s    = state_r;
        crc_s      = crc_r;
        data_cnt_s = data_cnt_r;
        pre_cnt_s  = pre_cnt_r;
        fcs_idx_s  = fcs_idx_r;
        ifg_cnt_s  = ifg_cnt_r;
        tx_en_s    = 1'b0;
        tx_err_s   = 1'b0;
        tx_data_s  = 8'h00;
        ovr_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_tx_en && !en_prev_r) begin
                    tx_en_s   = 1'b1;
                    tx_data_s = in_tx_data;
                    if (in_tx_data == ETH_SFD) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s   = ST_PREAMBLE;
                        pre_cnt_s = 4'd1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (!in_tx_en) begin
                    state_s = ST_DRAIN;
                end else begin
                    tx_en_s   = 1'b1;
                    tx_data_s = in_tx_data;
                    if (in_tx_data == ETH_SFD) begin
                        state_s = ST_DATA;
                    end else begin
                        pre_cnt_s = pre_cnt_r + 4'd1;
                        state_s   = (pre_cnt_r + 4'd1 >= MAX_PRE) ? ST_DRAIN : ST_PREAMBLE;
                    end
                end
            end
            ST_DATA, ST_PAD: begin
                ovr_s   = (state_r == ST_PAD) && in_tx_en;
                tx_en_s = 1'b1;
                if (state_r == ST_DATA && in_tx_en) begin
                    tx_data_s  = in_tx_data;
                    crc_s      = crc_next_s;
                    data_cnt_s = data_cnt_inc_s;
                end else if (data_cnt_r < MIN_C) begin
                    crc_s      = crc_next_s;
                    data_cnt_s = data_cnt_inc_s;
                    state_s    = ST_PAD;
                end else begin
                    tx_data_s = fcs_s[7:0];
                    fcs_idx_s = 2'd1;
                    state_s   = ST_FCS;
                end
            end
            ST_FCS: begin
                ovr_s   = in_tx_en;
                tx_en_s = 1'b1;
                case (fcs_idx_r)
                    2'd1:    tx_data_s = fcs_s[15:8];
                    2'd2:    tx_data_s = fcs_s[23:16];
                    2'd3:    tx_data_s = fcs_s[31:24];
                    default: tx_data_s = fcs_s[7:0];
                endcase
                if (fcs_idx_r == 2'd3) begin
                    state_s   = ST_IFG;
                    ifg_cnt_s = 8'd0;
                end else begin
                    fcs_idx_s = fcs_idx_r + 2'd1;
                end
            end
            ST_IFG: begin
                ovr_s = in_tx_en;
                if (ifg_cnt_r == IFG_LAST) begin
                    state_s    = ST_IDLE;
                    crc_s      = CRC32_INIT;
                    data_cnt_s = 11'd0;
                    pre_cnt_s  = 4'd0;
                    fcs_idx_s  = 2'd0;
                    ifg_cnt_s  = 8'd0;
                end else begin
                    ifg_cnt_s = ifg_cnt_r + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (in_tx_en) begin
                    tx_en_s  = 1'b1;
                    tx_err_s = 1'b1;
                end else begin
                    state_s   = ST_IFG;
                    ifg_cnt_s = 8'd0;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered GMII outputs.
    always_ff @(posedge gmii_clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            crc_r        <= CRC32_INIT;
            data_cnt_r   <= 11'd0;
            pre_cnt_r    <= 4'd0;
            fcs_idx_r    <= 2'd0;
            ifg_cnt_r    <= 8'd0;
            en_prev_r    <= 1'b0;
            gmii_tx_en   <= 1'b0;
            gmii_tx_err  <= 1'b0;
            gmii_tx_data <= 8'h00;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_r      <= state_s;
            crc_r        <= crc_s;
            data_cnt_r   <= data_cnt_s;
            pre_cnt_r    <= pre_cnt_s;
            fcs_idx_r    <= fcs_idx_s;
            ifg_cnt_r    <= ifg_cnt_s;
            en_prev_r    <= in_tx_en;
            gmii_tx_en   <= tx_en_s;
            gmii_tx_err  <= tx_err_s;
            gmii_tx_data <= tx_data_s;
            busy         <= (state_r != ST_IDLE);
            overrun      <= ovr_s;
        end
    end

endmodule
